fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the picoMIPS core. Drives the program memory address, registers the returned instruction word into an instruction register (IR), and hands it to decode/execute with a valid flag. The block owns the program counter (PC), including sequential increment, relative and absolute branches, stall, and a halt/resume wait state used for the switch handshake in the matrix-calculation programs.

## Interface
Parameters:
- Psize, 4, program address width (memory depth 2^Psize)
- Isize, 24, instruction MSB index; instruction words are Isize+1 bits wide

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- address  out  Psize  program memory address (= PC)
- I  in  Isize+1  instruction word returned combinationally by program memory for `address`
- instr  out  Isize+1  registered instruction (IR)
- instr_pc  out  Psize  address the IR contents were fetched from
- instr_valid  out  1  IR holds an instruction to execute this cycle
- stall  in  1  freeze PC, IR, and state
- rel_branch  in  1  take relative branch: target = instr_pc + sign-extended branch_off
- abs_branch  in  1  take absolute branch: target = branch_addr
- branch_off  in  Psize  two's-complement offset
- branch_addr  in  Psize  absolute target
- halt_req  in  1  enter HALT after the current instruction
- resume  in  1  leave HALT
- halted  out  1  high while in HALT

## Operation
- States: RUN, HALT. Reset enters RUN.
- RUN, no stall, no branch: IR <= I, instr_pc <= PC, PC <= PC+1 mod 2^Psize, instr_valid <= 1.
- Branch inputs are honoured only when instr_valid=1 and stall=0; otherwise they are ignored.
- Taken branch: PC <= target, instr_valid <= 0 (one bubble; the sequentially fetched word is discarded). IR and instr_pc hold their values.
- rel_branch and abs_branch both high: abs_branch wins.
- Target arithmetic is Psize bits, modulo 2^Psize. Wrap in both directions is legal, e.g. Psize=4: 15+1 → 0 and 2+(−3) → 15.
- halt_req with instr_valid=1 and stall=0: go to HALT, instr_valid <= 0, PC frozen. If a branch is also taken, PC <= target before freezing.
- HALT: address=PC is held, instr_valid=0, halted=1. Branch inputs and halt_req are ignored.
- resume in HALT: go to RUN. The next edge fetches from the held PC. resume in RUN is ignored.
- stall=1 holds PC, IR, instr_pc, instr_valid, and state in every state, and overrides resume.

## Timing
- Reset values: address=0, instr=0, instr_pc=0, instr_valid=0, halted=0, state RUN.
- First rising edge after reset deasserts: instr=mem[0], instr_pc=0, instr_valid=1, address=1.
- Fetch latency is 1 cycle from address to instr. Branch penalty is 1 bubble cycle. The target instruction is valid 2 edges after branch assertion.
- halted rises on the edge that accepts halt_req. On the edge that accepts resume, halted falls; instr_valid rises on the following edge.
- Reset asserted mid-operation clears all state immediately (asynchronous), including from HALT or a pending branch.
- `address` is a registered output with no combinational path from any input.

## Configuration
- FETCH_ICOUNT_EN defined: adds output icount [15:0], reset 0. It increments on every edge where instr_valid=1 and stall=0, saturates at 16'hFFFF, and is not cleared by halt or resume.
- Not defined: the icount port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset release with mem[k]=k+100: 16 edges yield instr 100..115 with instr_pc 0..15. address wraps 15→0 and the next instr is 100 again.
- At instr_pc=5, pulse rel_branch with branch_off=4'b1101 (−3): the next edge gives instr_valid=0 and address=2. The edge after gives instr=mem[2], instr_pc=2.
- rel_branch and abs_branch together with branch_addr=9: PC goes to 9. A branch pulsed while stall=1 or instr_valid=0 leaves the sequential flow unchanged.
- halt_req at instr_pc=3: halted=1, address=4 held for 10 cycles, instr_valid=0. A resume pulse then gives instr=mem[4] one edge later. resume during stall has no effect.
- Assert reset while in HALT and again one cycle after a branch: all outputs return to their reset values immediately, and fetch restarts at 0.
- With FETCH_ICOUNT_EN: 7 valid instructions, 1 branch bubble, and 3 stall cycles give icount=7. Forcing the count near its limit shows it saturating at FFFF.

Source files
------------

// File: rtl/fetch_unit.sv
// picoMIPS instruction fetch stage: owns the PC, the instruction register and the RUN/HALT wait state.
// Optional FETCH_ICOUNT_EN adds a saturating 16-bit retired-instruction counter on output icount.
module fetch_unit #(
    parameter int Psize = 4,
    parameter int Isize = 24
) (
    input  logic             clk,
    input  logic             reset,
    output logic [Psize-1:0] address,
    input  logic [Isize:0]   I,
    output logic [Isize:0]   instr,
    output logic [Psize-1:0] instr_pc,
    output logic             instr_valid,
    input  logic             stall,
    input  logic             rel_branch,
    input  logic             abs_branch,
    input  logic [Psize-1:0] branch_off,
    input  logic [Psize-1:0] branch_addr,
    input  logic             halt_req,
    input  logic             resume,
    output logic             halted
`ifdef FETCH_ICOUNT_EN
    ,
    output logic [15:0]      icount
`endif
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [Psize-1:0] pc_q, pc_d;
    logic [Isize:0]   ir_q, ir_d;
    logic [Psize-1:0] ipc_q, ipc_d;
    logic             valid_q, valid_d;

    logic             take_branch;
    logic [Psize-1:0] branch_target;

    // Branches only act on a live instruction; abs wins over rel. Adding the
    // Psize-bit offset modulo 2^Psize is the same as sign-extending it.
    assign take_branch   = valid_q && (rel_branch || abs_branch);
    assign branch_target = abs_branch ? branch_addr : ipc_q + branch_off;

    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no path leaves it unassigned (no latch).
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;

        if (!stall) begin
            case (state_q)
                RUN: begin
                    if (valid_q && halt_req) begin
                        state_d = HALT;
                        valid_d = 1'b0;
                        if (take_branch) begin
                            pc_d = branch_target;
                        end
                    end else if (take_branch) begin
                        pc_d    = branch_target;
                        valid_d = 1'b0;
                    end else begin
                        ir_d    = I;
                        ipc_d   = pc_q;
                        pc_d    = pc_q + Psize'(1);
                        valid_d = 1'b1;
                    end
                end
                HALT: begin
                    valid_d = 1'b0;
                    if (resume) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            pc_q    <= '0;
            ir_q    <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
        end
    end

    assign address     = pc_q;
    assign instr       = ir_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = valid_q;
    assign halted      = (state_q == HALT);

`ifdef FETCH_ICOUNT_EN
    logic [15:0] icount_q, icount_d;

    // Counts instructions handed to execute; halt/resume leave it alone.
    always_comb begin
        icount_d = icount_q;
        if (valid_q && !stall && (icount_q != 16'hFFFF)) begin
            icount_d = icount_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            icount_q <= '0;
        end else begin
            icount_q <= icount_d;
        end
    end

    assign icount = icount_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, hand-written corner sequences and a randomized run against a reference model.
module tb_fetch_unit;

    localparam int PS = 4;
    localparam int IS = 24;
    localparam int DEPTH = 1 << PS;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [PS-1:0] address;
    logic [IS:0]   I;
    logic [IS:0]   instr;
    logic [PS-1:0] instr_pc;
    logic          instr_valid;
    logic          stall = 1'b0;
    logic          rel_branch = 1'b0;
    logic          abs_branch = 1'b0;
    logic [PS-1:0] branch_off = '0;
    logic [PS-1:0] branch_addr = '0;
    logic          halt_req = 1'b0;
    logic          resume = 1'b0;
    logic          halted;
`ifdef FETCH_ICOUNT_EN
    logic [15:0]   icount;
`endif

    logic [IS:0] mem [DEPTH];
    assign I = mem[address];

    fetch_unit #(.Psize(PS), .Isize(IS)) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .I           (I),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .stall       (stall),
        .rel_branch  (rel_branch),
        .abs_branch  (abs_branch),
        .branch_off  (branch_off),
        .branch_addr (branch_addr),
        .halt_req    (halt_req),
        .resume      (resume),
        .halted      (halted)
`ifdef FETCH_ICOUNT_EN
        ,
        .icount      (icount)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; rel_branch = 0; abs_branch = 0;
        branch_off = '0; branch_addr = '0; halt_req = 0; resume = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " address"}, 32'(address), 0);
        check({tag, " instr"}, 32'(instr), 0);
        check({tag, " instr_pc"}, 32'(instr_pc), 0);
        check({tag, " instr_valid"}, 32'(instr_valid), 0);
        check({tag, " halted"}, 32'(halted), 0);
`ifdef FETCH_ICOUNT_EN
        check({tag, " icount"}, 32'(icount), 0);
`endif
    endtask

    // Reset asserted between edges, checked at once, released on a falling edge.
    task automatic apply_reset(input string tag);
        clear_inputs();
        @(negedge clk);
        reset = 0;
        #1;
        check_reset_values(tag);
        @(negedge clk);
        reset = 1;
    endtask

    task automatic fill_linear();
        for (int k = 0; k < DEPTH; k++) mem[k] = 25'(k + 100);
    endtask

    typedef struct {
        bit   stall, rel, abs;
        int   off, baddr;
        bit   halt, res;
        int   e_addr;
        bit   e_valid;
        int   e_ipc;
        bit   e_halted;
    } vec_t;

    function automatic vec_t mk(bit s, bit r, bit a, int off, int ba, bit h, bit rs,
                                int ea, bit ev, int eipc, bit eh);
        vec_t v;
        v.stall = s; v.rel = r; v.abs = a; v.off = off; v.baddr = ba;
        v.halt = h; v.res = rs; v.e_addr = ea; v.e_valid = ev; v.e_ipc = eipc; v.e_halted = eh;
        return v;
    endfunction

    // Reference model state, advanced from the behavioural rules of the fetch stage.
    int m_pc, m_ir, m_ipc, m_valid, m_halted;
`ifdef FETCH_ICOUNT_EN
    int m_icount;
`endif

    task automatic model_reset();
        m_pc = 0; m_ir = 0; m_ipc = 0; m_valid = 0; m_halted = 0;
`ifdef FETCH_ICOUNT_EN
        m_icount = 0;
`endif
    endtask

    task automatic model_step();
        int target;
        bit redirect;
`ifdef FETCH_ICOUNT_EN
        if (m_valid == 1 && !stall && m_icount < 65535) m_icount++;
`endif
        if (stall) return;
        if (m_halted == 1) begin
            m_valid = 0;
            if (resume) m_halted = 0;
            return;
        end
        redirect = (m_valid == 1) && (rel_branch || abs_branch);
        if (abs_branch) target = int'(branch_addr);
        else            target = (m_ipc + int'(branch_off)) % DEPTH;
        if (m_valid == 1 && halt_req) begin
            m_halted = 1;
            m_valid = 0;
            if (redirect) m_pc = target;
        end else if (redirect) begin
            m_pc = target;
            m_valid = 0;
        end else begin
            m_ir = int'(mem[m_pc]);
            m_ipc = m_pc;
            m_pc = (m_pc + 1) % DEPTH;
            m_valid = 1;
        end
    endtask

    vec_t tbl [20];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fill_linear();

        // Sequential sweep with wrap.
        apply_reset("reset");
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            check($sformatf("sweep instr %0d", k), 32'(instr), 32'(k + 100));
            check($sformatf("sweep instr_pc %0d", k), 32'(instr_pc), 32'(k));
            check($sformatf("sweep address %0d", k), 32'(address), 32'((k + 1) % DEPTH));
            check($sformatf("sweep valid %0d", k), 32'(instr_valid), 1);
        end
        tick();
        check("wrap instr", 32'(instr), 100);
        check("wrap instr_pc", 32'(instr_pc), 0);

        // Vector table: branches, stall, halt/resume, wrap in both directions.
        tbl[0]  = mk(0,0,0, 0, 0,0,0,  1,1, 0,0);
        tbl[1]  = mk(0,1,0, 5, 0,0,0,  5,0, 0,0);
        tbl[2]  = mk(0,1,0, 3, 0,0,0,  6,1, 5,0);
        tbl[3]  = mk(0,1,0,13, 0,0,0,  2,0, 5,0);
        tbl[4]  = mk(0,0,0, 0, 0,0,0,  3,1, 2,0);
        tbl[5]  = mk(0,1,1, 1, 9,0,0,  9,0, 2,0);
        tbl[6]  = mk(0,0,0, 0, 0,0,0, 10,1, 9,0);
        tbl[7]  = mk(1,0,1, 0, 0,0,0, 10,1, 9,0);
        tbl[8]  = mk(0,0,0, 0, 0,0,0, 11,1,10,0);
        tbl[9]  = mk(0,0,0, 0, 0,1,0, 11,0,10,1);
        tbl[10] = mk(0,0,1, 0, 3,1,0, 11,0,10,1);
        tbl[11] = mk(1,0,0, 0, 0,0,1, 11,0,10,1);
        tbl[12] = mk(0,0,0, 0, 0,0,1, 11,0,10,0);
        tbl[13] = mk(0,0,0, 0, 0,0,0, 12,1,11,0);
        tbl[14] = mk(0,0,1, 0,14,1,0, 14,0,11,1);
        tbl[15] = mk(0,0,0, 0, 0,0,1, 14,0,11,0);
        tbl[16] = mk(0,0,0, 0, 0,0,0, 15,1,14,0);
        tbl[17] = mk(0,0,0, 0, 0,0,0,  0,1,15,0);
        tbl[18] = mk(0,1,0,15, 0,0,0, 14,0,15,0);
        tbl[19] = mk(0,0,0, 0, 0,0,1, 15,1,14,0);

        apply_reset("table reset");
        for (int i = 0; i < 20; i++) begin
            stall = tbl[i].stall; rel_branch = tbl[i].rel; abs_branch = tbl[i].abs;
            branch_off = PS'(tbl[i].off); branch_addr = PS'(tbl[i].baddr);
            halt_req = tbl[i].halt; resume = tbl[i].res;
            tick();
            check($sformatf("vec%0d address", i), 32'(address), 32'(tbl[i].e_addr));
            check($sformatf("vec%0d valid", i), 32'(instr_valid), 32'(tbl[i].e_valid));
            check($sformatf("vec%0d instr_pc", i), 32'(instr_pc), 32'(tbl[i].e_ipc));
            check($sformatf("vec%0d halted", i), 32'(halted), 32'(tbl[i].e_halted));
            check($sformatf("vec%0d instr", i), 32'(instr), 32'(tbl[i].e_ipc + 100));
            clear_inputs();
        end

        // Halt at instr_pc=3, hold for 10 cycles, stalled resume, then resume.
        apply_reset("halt reset");
        repeat (4) tick();
        check("pre-halt instr_pc", 32'(instr_pc), 3);
        halt_req = 1;
        tick();
        halt_req = 0;
        check("halt halted", 32'(halted), 1);
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("halt hold address %0d", c), 32'(address), 4);
            check($sformatf("halt hold valid %0d", c), 32'(instr_valid), 0);
            check($sformatf("halt hold halted %0d", c), 32'(halted), 1);
        end
        stall = 1; resume = 1;
        tick();
        check("stalled resume halted", 32'(halted), 1);
        stall = 0;
        tick();
        resume = 0;
        check("resume halted", 32'(halted), 0);
        check("resume valid", 32'(instr_valid), 0);
        tick();
        check("post-resume instr", 32'(instr), 104);
        check("post-resume instr_pc", 32'(instr_pc), 4);
        check("post-resume valid", 32'(instr_valid), 1);

        // Asynchronous reset while halted.
        halt_req = 1;
        tick();
        halt_req = 0;
        check("halt again", 32'(halted), 1);
        reset = 0;
        #1;
        check_reset_values("reset in halt");
        @(negedge clk);
        reset = 1;
        tick();
        check("restart instr", 32'(instr), 100);
        check("restart address", 32'(address), 1);

        // Asynchronous reset one cycle after a branch.
        abs_branch = 1; branch_addr = 4'd7;
        tick();
        clear_inputs();
        check("branch pending address", 32'(address), 7);
        reset = 0;
        #1;
        check_reset_values("reset after branch");
        @(negedge clk);
        reset = 1;
        tick();
        check("restart2 instr_pc", 32'(instr_pc), 0);
        check("restart2 instr", 32'(instr), 100);

`ifdef FETCH_ICOUNT_EN
        // 7 valid instructions, 1 bubble, 3 stall cycles.
        apply_reset("icount reset");
        tick(); tick();
        abs_branch = 1; branch_addr = 4'd8;
        tick();
        clear_inputs();
        tick();
        stall = 1;
        repeat (3) tick();
        stall = 0;
        repeat (5) tick();
        check("icount seven", 32'(icount), 7);
        apply_reset("icount sat reset");
        repeat (65540) tick();
        check("icount saturate", 32'(icount), 32'h0000FFFF);
`endif

        // Randomized run against the reference model.
        for (int k = 0; k < DEPTH; k++) mem[k] = 25'($urandom);
        apply_reset("random reset");
        model_reset();
        for (int c = 0; c < 400; c++) begin
            stall       = ($urandom_range(0, 99) < 20);
            rel_branch  = ($urandom_range(0, 99) < 15);
            abs_branch  = ($urandom_range(0, 99) < 10);
            branch_off  = PS'($urandom_range(0, DEPTH - 1));
            branch_addr = PS'($urandom_range(0, DEPTH - 1));
            halt_req    = ($urandom_range(0, 99) < 6);
            resume      = ($urandom_range(0, 99) < 30);
            model_step();
            tick();
            check($sformatf("rand%0d address", c), 32'(address), 32'(m_pc));
            check($sformatf("rand%0d instr", c), 32'(instr), 32'(m_ir));
            check($sformatf("rand%0d instr_pc", c), 32'(instr_pc), 32'(m_ipc));
            check($sformatf("rand%0d valid", c), 32'(instr_valid), 32'(m_valid));
            check($sformatf("rand%0d halted", c), 32'(halted), 32'(m_halted));
`ifdef FETCH_ICOUNT_EN
            check($sformatf("rand%0d icount", c), 32'(icount), 32'(m_icount));
`endif
        end
        clear_inputs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
